// File: rtl/ddr_cmd_pkg.sv
//==============================================================================
// Module      : ddr_cmd_pkg
// Description : Shared DDR4 command-pin codes, power states and mode-register
//               selectors used by the command decoder and TimingFSM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ddr_cmd_pkg;

    typedef enum logic [1:0] {
        ACTIVE  = 2'b00,
        PWRDN   = 2'b01,
        SELFREF = 2'b10
    } pwr_state_t;

    // Raw {ras_n, cas_n, we_n} encodings when act_n is high
    typedef enum logic [2:0] {
        CMD_MRS  = 3'b000,
        CMD_REF  = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_RSVD = 3'b011,
        CMD_WR   = 3'b100,
        CMD_RD   = 3'b101,
        CMD_ZQC  = 3'b110,
        CMD_NOP  = 3'b111
    } cmd_code_t;

    localparam logic [2:0] MR0_SEL = 3'b000;
    localparam logic [2:0] MR3_SEL = 3'b011;
    localparam int         MPR_BIT = 2;
    localparam int         AP_BIT  = 10;

    typedef struct packed {
        logic act;
        logic cfg;
        logic mrr;
        logic mrw;
        logic pr;
        logic pra;
        logic rd;
        logic rda;
        logic refresh;
        logic wr;
        logic wra;
    } cmd_strb_t;

endpackage

`default_nettype wire

// File: rtl/ddr_pwr_fsm.sv
//==============================================================================
// Module      : ddr_pwr_fsm
// Description : CKE tracking and power-state machine; gates command decode and
//               produces PD/PDX/SRF/CKEH/CKEL pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ddr_pwr_fsm
    import ddr_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cke,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_ref,
    output logic       o_cmd_allow,
    output logic       o_err,
    output pwr_state_t o_pwr_state,
    output logic       o_pd,
    output logic       o_pdx,
    output logic       o_srf,
    output logic       o_ckeh,
    output logic       o_ckel
);

    pwr_state_t state_q, state_d;
    logic       cke_q;
    logic       pd_q,   pd_d;
    logic       pdx_q,  pdx_d;
    logic       srf_q,  srf_d;
    logic       ckeh_q, ckeh_d;
    logic       ckel_q, ckel_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACTIVE;
            cke_q   <= 1'b1;
            pd_q    <= 1'b0;
            pdx_q   <= 1'b0;
            srf_q   <= 1'b0;
            ckeh_q  <= 1'b0;
            ckel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cke_q   <= cke;
            pd_q    <= pd_d;
            pdx_q   <= pdx_d;
            srf_q   <= srf_d;
            ckeh_q  <= ckeh_d;
            ckel_q  <= ckel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pd_d        = 1'b0;
        pdx_d       = 1'b0;
        srf_d       = 1'b0;
        o_cmd_allow = 1'b0;
        o_err       = 1'b0;
        ckeh_d      = !cke_q && cke;
        ckel_d      = cke_q && !cke;

        case (state_q)
            ACTIVE: begin
                if (cke_q && cke) begin
                    o_cmd_allow = 1'b1;
                end else if (cke_q && !cke) begin
                    // Power-down entry: only DES/NOP or REF are legal on the falling CKE edge
                    if (!i_cmd_valid) begin
                        pd_d    = 1'b1;
                        state_d = PWRDN;
                    end else if (i_cmd_ref) begin
                        srf_d   = 1'b1;
                        state_d = SELFREF;
                    end else begin
                        o_err   = 1'b1;
                        state_d = PWRDN;
                    end
                end else begin
                    o_err = i_cmd_valid;
                end
            end
            default: begin
                if (!cke_q && cke) begin
                    pdx_d   = 1'b1;
                    state_d = ACTIVE;
                end
                o_err = i_cmd_valid;
            end
        endcase
    end

    assign o_pwr_state = state_q;
    assign o_pd        = pd_q;
    assign o_pdx       = pdx_q;
    assign o_srf       = srf_q;
    assign o_ckeh      = ckeh_q;
    assign o_ckel      = ckel_q;

endmodule

`default_nettype wire

// File: rtl/ddr4_cmd_decoder.sv
//==============================================================================
// Module      : ddr4_cmd_decoder
// Description : DDR4 command/address pin decoder with MR0/MR3 shadows, CKE
//               power tracking and sticky illegal-command flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ddr4_cmd_decoder
    import ddr_cmd_pkg::*;
#(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int ROWWIDTH = 17,
    parameter int COLWIDTH = 10
)(
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cke,
    input  logic                                    cs_n,
    input  logic                                    act_n,
    input  logic                                    ras_n,
    input  logic                                    cas_n,
    input  logic                                    we_n,
    input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0] bg_i,
    input  logic [BAWIDTH-1:0]                      ba_i,
    input  logic [13:0]                             a_i,
    output logic                                    ACT,
    output logic                                    BST,
    output logic                                    CFG,
    output logic                                    CKEH,
    output logic                                    CKEL,
    output logic                                    DPD,
    output logic                                    DPDX,
    output logic                                    MRR,
    output logic                                    MRW,
    output logic                                    PD,
    output logic                                    PDX,
    output logic                                    PR,
    output logic                                    PRA,
    output logic                                    RD,
    output logic                                    RDA,
    output logic                                    REF,
    output logic                                    SRF,
    output logic                                    WR,
    output logic                                    WRA,
    output logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0] bg,
    output logic [BAWIDTH-1:0]                      ba,
    output logic [ROWWIDTH-1:0]                     row,
    output logic [COLWIDTH-1:0]                     col,
    output logic [1:0]                              pwr_state,
    output logic [1:0]                              mr_bl,
    output logic                                    mpr_en,
    output logic                                    cmd_err
);

    localparam int BGW = (BGWIDTH > 0) ? BGWIDTH : 1;

    logic [2:0]    w_rcw;
    cmd_code_t     w_code;
    logic          w_cmd_valid;
    logic          w_cmd_ref;
    logic          w_cmd_allow;
    logic          w_pwr_err;
    logic          w_dec_err;
    pwr_state_t    w_pwr_state;
    logic [BGW-1:0] w_bg_pin;
    logic          w_mr_bg;
    logic [1:0]    w_ba_sel;

    cmd_strb_t          strb_q,   strb_d;
    logic [BGW-1:0]     bg_q,     bg_d;
    logic [BAWIDTH-1:0] ba_q,     ba_d;
    logic [ROWWIDTH-1:0] row_q,   row_d;
    logic [COLWIDTH-1:0] col_q,   col_d;
    logic [1:0]         mr_bl_q,  mr_bl_d;
    logic               mpr_en_q, mpr_en_d;
    logic               cmd_err_q, cmd_err_d;

    generate
        if (BGWIDTH > 0) begin : g_bg
            assign w_bg_pin = bg_i;
            assign w_mr_bg  = bg_i[0];
        end else begin : g_no_bg
            logic w_unused_bg;
            assign w_unused_bg = ^bg_i;
            assign w_bg_pin    = '0;
            assign w_mr_bg     = 1'b0;
        end
    endgenerate

    assign w_rcw       = {ras_n, cas_n, we_n};
    assign w_code      = cmd_code_t'(w_rcw);
    assign w_cmd_valid = !cs_n && (!act_n || (w_code != CMD_NOP));
    assign w_cmd_ref   = !cs_n && act_n && (w_code == CMD_REF);
    assign w_ba_sel    = 2'(ba_i);

    ddr_pwr_fsm u_pwr_fsm (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .i_cmd_valid (w_cmd_valid),
        .i_cmd_ref   (w_cmd_ref),
        .o_cmd_allow (w_cmd_allow),
        .o_err       (w_pwr_err),
        .o_pwr_state (w_pwr_state),
        .o_pd        (PD),
        .o_pdx       (PDX),
        .o_srf       (SRF),
        .o_ckeh      (CKEH),
        .o_ckel      (CKEL)
    );

    always_comb begin
        strb_d    = '0;
        w_dec_err = 1'b0;
        bg_d      = bg_q;
        ba_d      = ba_q;
        row_d     = row_q;
        col_d     = col_q;
        mr_bl_d   = mr_bl_q;
        mpr_en_d  = mpr_en_q;

        if (w_cmd_allow && !cs_n) begin
            if (!act_n) begin
                strb_d.act = 1'b1;
                row_d      = ROWWIDTH'({w_rcw, a_i});
            end else begin
                case (w_code)
                    CMD_MRS: begin
                        strb_d.mrw = 1'b1;
                        if ({w_mr_bg, w_ba_sel} == MR0_SEL)
                            mr_bl_d = a_i[1:0];
                        else if ({w_mr_bg, w_ba_sel} == MR3_SEL)
                            mpr_en_d = a_i[MPR_BIT];
                    end
                    CMD_REF:  strb_d.refresh = 1'b1;
                    CMD_PRE: begin
                        strb_d.pra = a_i[AP_BIT];
                        strb_d.pr  = !a_i[AP_BIT];
                    end
                    // Writes are illegal while the MPR page is selected
                    CMD_WR: begin
                        if (mpr_en_q) begin
                            w_dec_err = 1'b1;
                        end else begin
                            strb_d.wra = a_i[AP_BIT];
                            strb_d.wr  = !a_i[AP_BIT];
                        end
                    end
                    CMD_RD: begin
                        if (mpr_en_q) begin
                            strb_d.mrr = 1'b1;
                        end else begin
                            strb_d.rda = a_i[AP_BIT];
                            strb_d.rd  = !a_i[AP_BIT];
                        end
                    end
                    CMD_ZQC:  strb_d.cfg = 1'b1;
                    CMD_RSVD: w_dec_err  = 1'b1;
                    default: ;
                endcase
            end

            if (strb_d != '0) begin
                bg_d = w_bg_pin;
                ba_d = ba_i;
            end
            if (strb_d.rd || strb_d.rda || strb_d.wr || strb_d.wra || strb_d.mrr)
                col_d = COLWIDTH'(a_i);
        end

        cmd_err_d = cmd_err_q || w_dec_err || w_pwr_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_q    <= '0;
            bg_q      <= '0;
            ba_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            mr_bl_q   <= 2'b00;
            mpr_en_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            strb_q    <= strb_d;
            bg_q      <= bg_d;
            ba_q      <= ba_d;
            row_q     <= row_d;
            col_q     <= col_d;
            mr_bl_q   <= mr_bl_d;
            mpr_en_q  <= mpr_en_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // LPDDR-only strobes never fire in DDR4 mode
    assign BST  = 1'b0;
    assign DPD  = 1'b0;
    assign DPDX = 1'b0;

    assign ACT       = strb_q.act;
    assign CFG       = strb_q.cfg;
    assign MRR       = strb_q.mrr;
    assign MRW       = strb_q.mrw;
    assign PR        = strb_q.pr;
    assign PRA       = strb_q.pra;
    assign RD        = strb_q.rd;
    assign RDA       = strb_q.rda;
    assign REF       = strb_q.refresh;
    assign WR        = strb_q.wr;
    assign WRA       = strb_q.wra;
    assign bg        = bg_q;
    assign ba        = ba_q;
    assign row       = row_q;
    assign col       = col_q;
    assign pwr_state = w_pwr_state;
    assign mr_bl     = mr_bl_q;
    assign mpr_en    = mpr_en_q;
    assign cmd_err   = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr4_cmd_decoder.sv
//==============================================================================
// Module      : tb_ddr4_cmd_decoder
// Description : Directed and randomized bench for ddr4_cmd_decoder against a
//               command-name level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ddr4_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset, cke, cs_n, act_n, ras_n, cas_n, we_n;
    logic [1:0]  bg_i, ba_i;
    logic [13:0] a_i;
    logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX;
    logic PR, PRA, RD, RDA, REF, SRF, WR, WRA;
    logic [1:0]  bg, ba, pwr_state, mr_bl;
    logic [16:0] row;
    logic [9:0]  col;
    logic        mpr_en, cmd_err;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    int          m_pwr;
    bit          m_prev;
    logic [1:0]  m_bl, m_bg, m_ba;
    bit          m_mpr, m_err;
    logic [16:0] m_row;
    logic [9:0]  m_col;
    logic [18:0] m_strb;

    string names [19] = '{"ACT","BST","CFG","CKEH","CKEL","DPD","DPDX","MRR","MRW",
                          "PD","PDX","PR","PRA","RD","RDA","REF","SRF","WR","WRA"};

    always #5 clk = ~clk;

    ddr4_cmd_decoder dut (
        .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg_i(bg_i), .ba_i(ba_i), .a_i(a_i),
        .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD), .DPDX(DPDX),
        .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA),
        .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA), .bg(bg), .ba(ba), .row(row), .col(col),
        .pwr_state(pwr_state), .mr_bl(mr_bl), .mpr_en(mpr_en), .cmd_err(cmd_err)
    );

    function automatic logic [18:0] bit_of(string n);
        logic [18:0] one;
        one = 19'd1;
        for (int i = 0; i < 19; i++)
            if (names[i] == n) return one << (18 - i);
        return '0;
    endfunction

    function automatic logic [18:0] obs();
        return {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX,
                PR, PRA, RD, RDA, REF, SRF, WR, WRA};
    endfunction

    function automatic string pin_cmd();
        if (cs_n)   return "DES";
        if (!act_n) return "ACT";
        case ({ras_n, cas_n, we_n})
            3'b000:  return "MRW";
            3'b001:  return "REF";
            3'b010:  return a_i[10] ? "PRA" : "PR";
            3'b011:  return "RSV";
            3'b100:  return a_i[10] ? "WRA" : "WR";
            3'b101:  return a_i[10] ? "RDA" : "RD";
            3'b110:  return "CFG";
            default: return "NOP";
        endcase
    endfunction

    task automatic issue(string c);
        string      s;
        logic [2:0] sel;
        s = c;
        if (c == "RSV") begin m_err = 1; s = ""; end
        if ((c == "RD" || c == "RDA") && m_mpr) s = "MRR";
        if ((c == "WR" || c == "WRA") && m_mpr) begin m_err = 1; s = ""; end
        if (s == "" || s == "DES" || s == "NOP") return;
        m_strb |= bit_of(s);
        m_bg = bg_i;
        m_ba = ba_i;
        if (s == "ACT") m_row = {ras_n, cas_n, we_n, a_i};
        if (s == "RD" || s == "RDA" || s == "WR" || s == "WRA" || s == "MRR") m_col = a_i[9:0];
        if (s == "MRW") begin
            sel = {bg_i[0], ba_i};
            if (sel == 3'd0) m_bl  = a_i[1:0];
            if (sel == 3'd3) m_mpr = a_i[2];
        end
    endtask

    task automatic model_step();
        string c;
        bit    quiet;
        m_strb = '0;
        if (reset) begin
            m_pwr = 0; m_prev = 1; m_bl = 0; m_mpr = 0; m_err = 0;
            m_bg = 0; m_ba = 0; m_row = 0; m_col = 0;
            return;
        end
        c     = pin_cmd();
        quiet = (c == "DES" || c == "NOP");
        if (!m_prev && cke) m_strb |= bit_of("CKEH");
        if (m_prev && !cke) m_strb |= bit_of("CKEL");
        if (m_pwr == 0 && m_prev && cke) begin
            issue(c);
        end else if (m_pwr == 0 && m_prev) begin
            if (quiet)             begin m_strb |= bit_of("PD");  m_pwr = 1; end
            else if (c == "REF")   begin m_strb |= bit_of("SRF"); m_pwr = 2; end
            else                   begin m_err = 1;               m_pwr = 1; end
        end else if (m_pwr != 0 && !m_prev && cke) begin
            m_strb |= bit_of("PDX");
            m_pwr = 0;
            if (!quiet) m_err = 1;
        end else if (!quiet) begin
            m_err = 1;
        end
        m_prev = cke;
    endtask

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        tests++;
        assert (o === e) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        chk("strobes",   32'(obs()),     32'(m_strb));
        chk("pwr_state", 32'(pwr_state), 32'(m_pwr));
        chk("mr_bl",     32'(mr_bl),     32'(m_bl));
        chk("mpr_en",    32'(mpr_en),    32'(m_mpr));
        chk("cmd_err",   32'(cmd_err),   32'(m_err));
        chk("bg",        32'(bg),        32'(m_bg));
        chk("ba",        32'(ba),        32'(m_ba));
        chk("row",       32'(row),       32'(m_row));
        chk("col",       32'(col),       32'(m_col));
    endtask

    task automatic drive(input bit rs, input bit ck, input bit cs, input bit act,
                         input logic [2:0] rcw, input logic [1:0] g, input logic [1:0] b,
                         input logic [13:0] a);
        reset = rs; cke = ck; cs_n = cs; act_n = act;
        {ras_n, cas_n, we_n} = rcw;
        bg_i = g; ba_i = b; a_i = a;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 1, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        @(negedge clk);
        repeat (3) step();
        chk("rst_strobes", 32'(obs()),     32'h0);
        chk("rst_pwr",     32'(pwr_state), 32'h0);
        chk("rst_mr_bl",   32'(mr_bl),     32'h0);
        chk("rst_mpr",     32'(mpr_en),    32'h0);
        chk("rst_err",     32'(cmd_err),   32'h0);

        drive(0, 1, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        step();

        drive(0, 1, 0, 0, 3'b101, 2'd1, 2'd1, 14'h0123);
        step();
        chk("act_pulse", 32'(ACT), 32'h1);
        chk("act_bg",    32'(bg),  32'h1);
        chk("act_ba",    32'(ba),  32'h1);
        chk("act_row",   32'(row), 32'h14123);
        drive(0, 1, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        step();
        chk("act_one_cycle", 32'(ACT), 32'h0);

        drive(0, 1, 0, 1, 3'b101, 2'd2, 2'd3, 14'h07F8);
        step();
        chk("rda_pulse", 32'(RDA), 32'h1);
        chk("rda_no_rd", 32'(RD),  32'h0);
        chk("rda_col",   32'(col), 32'h3F8);
        drive(0, 1, 0, 1, 3'b101, 2'd2, 2'd3, 14'h03F8);
        step();
        chk("rd_pulse", 32'(RD), 32'h1);
        drive(0, 1, 0, 1, 3'b010, 2'd0, 2'd1, 14'h0400);
        step();
        chk("pra_pulse", 32'(PRA), 32'h1);

        drive(0, 1, 0, 1, 3'b000, 2'd0, 2'd3, 14'h0004);
        step();
        chk("mr3_mpr", 32'(mpr_en), 32'h1);
        drive(0, 1, 0, 1, 3'b101, 2'd0, 2'd0, 14'h0010);
        step();
        chk("mrr_pulse", 32'(MRR), 32'h1);
        chk("mrr_no_rd", 32'(RD),  32'h0);
        drive(0, 1, 0, 1, 3'b100, 2'd0, 2'd0, 14'h0020);
        step();
        chk("mpr_wr_err", 32'(cmd_err), 32'h1);
        chk("mpr_wr_drop", 32'(WR), 32'h0);
        drive(0, 1, 0, 1, 3'b000, 2'd0, 2'd0, 14'h0002);
        step();
        chk("mr0_bl", 32'(mr_bl), 32'h2);
        drive(0, 1, 0, 1, 3'b000, 2'd0, 2'd3, 14'h0000);
        step();

        drive(1, 1, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        step();
        drive(0, 1, 0, 1, 3'b000, 2'd0, 2'd0, 14'h0001);
        step();

        drive(0, 0, 0, 1, 3'b001, 2'd0, 2'd0, 14'h0);
        step();
        chk("srf_pulse", 32'(SRF),       32'h1);
        chk("srf_ckel",  32'(CKEL),      32'h1);
        chk("srf_noref", 32'(REF),       32'h0);
        chk("srf_state", 32'(pwr_state), 32'h2);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 3'b101, 2'd0, 2'd0, 14'h0155);
            step();
            chk("cke_low_quiet", 32'(obs()), 32'h0);
        end
        chk("cke_low_err", 32'(cmd_err), 32'h1);
        drive(0, 1, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        step();
        chk("pdx_pulse",  32'(PDX),       32'h1);
        chk("pdx_ckeh",   32'(CKEH),      32'h1);
        chk("pdx_active", 32'(pwr_state), 32'h0);

        drive(0, 0, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        step();
        chk("pd_pulse", 32'(PD),        32'h1);
        chk("pd_state", 32'(pwr_state), 32'h1);
        drive(1, 0, 0, 1, 3'b111, 2'd0, 2'd0, 14'h0);
        step();
        chk("pd_reset_state",   32'(pwr_state), 32'h0);
        chk("pd_reset_strobes", 32'(obs()),     32'h0);

        for (int n = 0; n < 600; n++) begin
            bit rs, ck;
            rs = ($urandom_range(0, 49) == 0);
            if (m_pwr == 0) ck = ($urandom_range(0, 9) != 0);
            else            ck = ($urandom_range(0, 3) == 0);
            drive(rs, ck, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                  3'($urandom), 2'($urandom), 2'($urandom), 14'($urandom));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
